// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier.
//   MULT_WIDTH : default operand width (hi/lo are each this wide)
//   MULT_CNT_W : iteration counter width for the default operand width
//   state_e    : controller states IDLE/RUN/FIX
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage : mult_pkg

// File: rtl/mult_sign_fix.sv
// Combinational sign handling around the unsigned shift-add core.
// Converts operands to unsigned magnitudes at start capture, and conditionally
// negates the unsigned 2*WIDTH accumulator when the result must be negative.
//   a, b       : raw operands
//   is_signed  : 1 = treat operands as two's complement
//   sa, sb     : operand sign flags (always 0 for unsigned operations)
//   mag_a/b    : unsigned magnitudes; |most-negative| is itself as unsigned
//   acc        : unsigned product accumulator
//   negate     : 1 = result is negative
//   acc_fixed  : acc, or its two's-complement negation when negate=1
module mult_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               sa,
    output logic               sb,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    input  logic [2*WIDTH-1:0] acc,
    input  logic               negate,
    output logic [2*WIDTH-1:0] acc_fixed
);

    assign sa = is_signed & a[WIDTH-1];
    assign sb = is_signed & b[WIDTH-1];

    // Negating the most-negative value wraps back to itself, which is exactly
    // its magnitude when read as unsigned, so no overflow handling is needed.
    assign mag_a = sa ? (~a + WIDTH'(1)) : a;
    assign mag_b = sb ? (~b + WIDTH'(1)) : b;

    assign acc_fixed = negate ? (~acc + (2*WIDTH)'(1)) : acc;

endmodule : mult_sign_fix

// File: rtl/seq_mult.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU.
// One partial product per clock; 34 edges from start to done falling.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   a, b      : operands, sampled only when start=1
//   is_signed : 1 = signed multiply, sampled when start=1
//   start     : begin (or restart) an operation; wins in every state
//   busy      : high while an operation is in progress
//   done      : one-cycle pulse when hi/lo take the new product
//   hi, lo    : upper/lower halves of the product, held until the next FIX
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [2*WIDTH-1:0] acc_fixed;
    logic [2*WIDTH-1:0] partial;

    mult_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .sa        (sa),
        .sb        (sb),
        .mag_a     (mag_a_in),
        .mag_b     (mag_b_in),
        .acc       (acc_q),
        .negate    (neg_q),
        .acc_fixed (acc_fixed)
    );

    assign partial = {{WIDTH{1'b0}}, mag_a_q} << count_q;

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        if (start) begin
            // Restart has priority over RUN and FIX: the aborted operation
            // never reaches hi/lo and never pulses done.
            state_d = RUN;
            count_d = '0;
            mag_a_d = mag_a_in;
            mag_b_d = mag_b_in;
            neg_d   = sa ^ sb;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                RUN: begin
                    if (mag_b_q[count_q]) begin
                        acc_d = acc_q + partial;
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    {hi_d, lo_d} = acc_fixed;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule : seq_mult

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed cases, random operands against an
// arithmetic product model, operand stability, restart, and async reset.
module tb_seq_mult;

    logic        clock;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    // Result the DUT should currently be holding on hi/lo.
    logic [63:0] held;

    seq_mult dut (
        .clock     (clock),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer multiplication of the operands as the ISA reads them.
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
        longint sx, sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full operation with cycle-accurate checks. With scramble=1 the operand
    // inputs change every cycle while busy.
    task automatic run_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic s_i,
                          input bit scramble, input string tag);
        logic [63:0] exp;
        exp = ref_prod(a_i, b_i, s_i);
        a = a_i; b = b_i; is_signed = s_i; start = 1'b1;
        tick();                         // E0
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (scramble) begin
                a = $urandom; b = $urandom; is_signed = 1'($urandom);
            end
            tick();                     // E0+k
            check({tag, " busy_run"}, 64'(busy), 64'd1);
            check({tag, " done_run"}, 64'(done), 64'd0);
        end
        check({tag, " hold_run"}, {hi, lo}, held);
        tick();                         // E0+33
        check({tag, " done_pulse"}, 64'(done), 64'd1);
        check({tag, " busy_fall"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
        held = exp;
        tick();                         // E0+34
        check({tag, " done_low"}, 64'(done), 64'd0);
        check({tag, " hold_idle"}, {hi, lo}, held);
    endtask

    initial begin
        int dones;
        reset = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        held = '0;
        #23;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        reset = 1'b1;
        tick();

        // Directed cases with known answers, also checked against the model.
        run_op(32'd7, 32'd9, 1'b0, 1'b0, "u7x9");
        check("u7x9 literal", {hi, lo}, 64'h0000_0000_0000_003F);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, "s-3x5");
        check("s-3x5 literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "u-3x5");
        check("u-3x5 literal", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "s_min_sq");
        check("s_min_sq literal", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "u_max_sq");
        check("u_max_sq literal", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_m1_sq");
        check("s_m1_sq literal", {hi, lo}, 64'h0000_0000_0000_0001);

        // Operands must be latched at start.
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, "stable");
        check("stable literal", {hi, lo}, 64'h0000_0001_0000_0000);

        // Random operands against the model.
        for (int i = 0; i < 24; i++) begin
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom), "rand");
        end

        // Restart at E0+10: one done only, at (E0+10)+33, for 2x3.
        a = 32'd6; b = 32'd7; is_signed = 1'b0; start = 1'b1;
        tick();                         // E0
        start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        a = 32'd2; b = 32'd3; start = 1'b1;
        tick();                         // E0+10
        start = 1'b0;
        dones = 0;
        for (int k = 11; k <= 60; k++) begin
            tick();
            if (done) dones++;
            if (k == 33) begin
                check("restart no_done_old", 64'(done), 64'd0);
                check("restart hold_old", {hi, lo}, held);
            end
            if (k == 43) begin
                check("restart done_new", 64'(done), 64'd1);
                check("restart result", {hi, lo}, ref_prod(32'd2, 32'd3, 1'b0));
                held = ref_prod(32'd2, 32'd3, 1'b0);
            end
        end
        check("restart done_count", 64'(dones), 64'd1);

        // start arriving in the FIX cycle: restart wins, no update, no done.
        a = 32'd11; b = 32'd13; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 32; k++) tick();
        a = 32'd17; b = 32'd19; start = 1'b1;
        tick();                         // FIX edge with start high
        start = 1'b0;
        check("fixstart no_done", 64'(done), 64'd0);
        check("fixstart busy", 64'(busy), 64'd1);
        check("fixstart hold", {hi, lo}, held);
        for (int k = 1; k <= 33; k++) tick();
        check("fixstart done_new", 64'(done), 64'd1);
        check("fixstart result", {hi, lo}, ref_prod(32'd17, 32'd19, 1'b0));
        held = ref_prod(32'd17, 32'd19, 1'b0);
        tick();

        // Asynchronous reset mid-operation, between clock edges.
        a = 32'h1234; b = 32'h5678; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        #2;
        reset = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst hilo", {hi, lo}, 64'd0);
        held = '0;
        tick();
        #2;
        reset = 1'b1;
        tick();
        check("postrst done", 64'(done), 64'd0);
        run_op(32'd5, 32'd5, 1'b0, 1'b0, "u5x5");
        check("u5x5 literal", {hi, lo}, 64'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_mult
